// File: rtl/esfa_test_sequencer.sv
// Self-test sequencer: fetches NUM_INSTR ROM words, drives the datapath, checks results and reports one status byte over UART.
// Optional build macro ESFA_SEQ_ERR_CONTINUE_EN: report every mismatch and keep running instead of stopping at the first one.
module esfa_test_sequencer #(
    parameter int NUM_INSTR = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [55:0] rom_data,
    output logic        dut_we,
    output logic [7:0]  dut_index,
    output logic [7:0]  dut_value,
    output logic [7:0]  dut_selector,
    output logic        dut_valid,
    input  logic        res_bool,
    input  logic [7:0]  res_value,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic        pass
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_CHECK  = 3'd3,
        ST_REPORT = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [7:0] LAST_IDX  = 8'(NUM_INSTR - 1);
    localparam logic [7:0] PASS_BYTE = 8'h3E;
    localparam logic [7:0] FAIL_BYTE = 8'h21;

    state_t     state_r, state_s;
    logic [7:0] rom_addr_r, rom_addr_s;
    logic       dut_we_r, dut_we_s;
    logic [7:0] dut_index_r, dut_index_s;
    logic [7:0] dut_value_r, dut_value_s;
    logic [7:0] dut_selector_r, dut_selector_s;
    logic       dut_valid_r, dut_valid_s;
    logic [7:0] tx_data_r, tx_data_s;
    logic       tx_valid_r, tx_valid_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic       pass_r, pass_s;
    logic       final_r, final_s;
    logic       err_seen_r, err_seen_s;
    logic       mismatch_s;
    logic       last_s;
    logic       unused_s;

    assign unused_s = ^{rom_data[55:49], rom_data[39:33], rom_data[7:1]};

    // Next-state and next-output logic; res_* are judged on the edge closing the dut_valid cycle.
    always_comb begin
        state_s        = state_r;
        rom_addr_s     = rom_addr_r;
        dut_we_s       = dut_we_r;
        dut_index_s    = dut_index_r;
        dut_value_s    = dut_value_r;
        dut_selector_s = dut_selector_r;
        dut_valid_s    = 1'b0;
        tx_data_s      = tx_data_r;
        tx_valid_s     = tx_valid_r;
        busy_s         = busy_r;
        done_s         = done_r;
        pass_s         = pass_r;
        final_s        = final_r;
        err_seen_s     = err_seen_r;
        mismatch_s     = rom_data[48] &&
                         ((res_bool != rom_data[32]) || (res_value != rom_data[31:24]));
        last_s         = (rom_addr_r == LAST_IDX);

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s    = ST_FETCH;
                    rom_addr_s = 8'd0;
                    busy_s     = 1'b1;
                    done_s     = 1'b0;
                    pass_s     = 1'b0;
                    err_seen_s = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_FETCH: begin
                state_s = ST_ISSUE;
            end
            ST_ISSUE: begin
                dut_we_s       = rom_data[0];
                dut_index_s    = rom_data[15:8];
                dut_value_s    = rom_data[23:16];
                dut_selector_s = rom_data[47:40];
                dut_valid_s    = 1'b1;
                state_s        = ST_CHECK;
            end
            ST_CHECK: begin
                if (mismatch_s) begin
                    err_seen_s = 1'b1;
                    tx_data_s  = rom_addr_r;
                    tx_valid_s = 1'b1;
                    state_s    = ST_REPORT;
`ifdef ESFA_SEQ_ERR_CONTINUE_EN
                    final_s    = 1'b0;
`else
                    final_s    = 1'b1;
`endif
                end else if (last_s) begin
                    tx_data_s  = err_seen_r ? FAIL_BYTE : PASS_BYTE;
                    tx_valid_s = 1'b1;
                    final_s    = 1'b1;
                    state_s    = ST_REPORT;
                end else begin
                    rom_addr_s = rom_addr_r + 8'd1;
                    state_s    = ST_FETCH;
                end
            end
            ST_REPORT: begin
                if (tx_ready) begin
                    tx_valid_s = 1'b0;
                    if (final_r) begin
                        state_s = ST_DONE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        pass_s  = ~err_seen_r;
                    end else if (last_s) begin
                        // A mismatch on the last instruction still owes the closing summary byte.
                        tx_data_s  = FAIL_BYTE;
                        tx_valid_s = 1'b1;
                        final_s    = 1'b1;
                    end else begin
                        rom_addr_s = rom_addr_r + 8'd1;
                        state_s    = ST_FETCH;
                    end
                end else begin
                    tx_valid_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; async reset drops everything to the idle picture immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            rom_addr_r     <= 8'd0;
            dut_we_r       <= 1'b0;
            dut_index_r    <= 8'd0;
            dut_value_r    <= 8'd0;
            dut_selector_r <= 8'd0;
            dut_valid_r    <= 1'b0;
            tx_data_r      <= 8'd0;
            tx_valid_r     <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            pass_r         <= 1'b0;
            final_r        <= 1'b0;
            err_seen_r     <= 1'b0;
        end else begin
            state_r        <= state_s;
            rom_addr_r     <= rom_addr_s;
            dut_we_r       <= dut_we_s;
            dut_index_r    <= dut_index_s;
            dut_value_r    <= dut_value_s;
            dut_selector_r <= dut_selector_s;
            dut_valid_r    <= dut_valid_s;
            tx_data_r      <= tx_data_s;
            tx_valid_r     <= tx_valid_s;
            busy_r         <= busy_s;
            done_r         <= done_s;
            pass_r         <= pass_s;
            final_r        <= final_s;
            err_seen_r     <= err_seen_s;
        end
    end

    assign rom_addr     = rom_addr_r;
    assign dut_we       = dut_we_r;
    assign dut_index    = dut_index_r;
    assign dut_value    = dut_value_r;
    assign dut_selector = dut_selector_r;
    assign dut_valid    = dut_valid_r;
    assign tx_data      = tx_data_r;
    assign tx_valid     = tx_valid_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign pass         = pass_r;

endmodule
